// File: rtl/uop_pkg.sv
// Shared micro-op types for the branch resolve path: branch kinds, queued
// prediction entries and resolve-unit FSM states.
package uop_pkg;

    typedef enum logic [1:0] {
        BCOND = 2'd0,
        B     = 2'd1,
        BL    = 2'd2,
        RET   = 2'd3
    } branch_kind_e;

    typedef struct packed {
        logic [63:0]  pc;
        branch_kind_e kind;
        logic         pred_taken;
        logic [63:0]  pred_target;
    } bru_entry_t;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_IDLE = 2'd1,
        ST_FIX  = 2'd2
    } bru_state_e;

    function automatic logic [63:0] fallthrough_pc(input logic [63:0] pc);
        return pc + 64'd4;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Decode-enqueue and execute-resolve handshakes into the branch resolve unit.
// master = decode/execute side, slave = branch_resolve_unit.
interface branch_resolve_unit_if;
    import uop_pkg::*;

    logic         dq_valid;
    logic         dq_ready;
    logic [63:0]  dq_pc;
    branch_kind_e dq_kind;
    logic         dq_pred_taken;
    logic [63:0]  dq_pred_target;

    logic         ex_valid;
    logic         ex_ready;
    logic         ex_taken;
    logic [63:0]  ex_target;

    modport master (
        output dq_valid, dq_pc, dq_kind, dq_pred_taken, dq_pred_target,
        output ex_valid, ex_taken, ex_target,
        input  dq_ready, ex_ready
    );

    modport slave (
        input  dq_valid, dq_pc, dq_kind, dq_pred_taken, dq_pred_target,
        input  ex_valid, ex_taken, ex_target,
        output dq_ready, ex_ready
    );

endinterface

// File: rtl/branch_fifo.sv
// In-order FIFO of predicted branches awaiting resolution; flush drops every
// entry and wins over a same-cycle push or pop.
module branch_fifo
    import uop_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  bru_entry_t push_data,
    input  logic       pop,
    input  logic       flush,
    output bru_entry_t head,
    output logic       full,
    output logic       empty
);

    localparam int PTR_W = $clog2(DEPTH);

    bru_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-side branch resolution: matches queued predictions against execute
// outcomes and drives corrections into branch_pred. BRU_STATS_EN adds counters.
//
// state | meaning
// BOOT  | one-cycle start_signal pulse with RESET_PC
// IDLE  | accept enqueues, resolve the oldest branch
// FIX   | second cycle of an out-of-range redirect (absolute target in x_pc)
module branch_resolve_unit
    import uop_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          OFF_W      = 19
) (
    input  logic                   clk_in,
    input  logic                   rst_N_in,
    branch_resolve_unit_if.slave   bus,
    output logic                   start_signal,
    output logic                   x_bcond_resolved,
    output logic                   x_taken,
    output logic [63:0]            x_pc,
    output logic                   x_pc_incorrect,
    output logic [OFF_W-1:0]       x_correction_offset,
    output logic                   flush_out,
    output logic                   bru_err
`ifdef BRU_STATS_EN
    ,
    output logic [31:0]            stat_resolved,
    output logic [31:0]            stat_mispred
`endif
);

    bru_state_e       state_q, state_d;
    logic [63:0]      fix_pc_q, fix_pc_d;
    bru_entry_t       head;
    logic             fifo_full, fifo_empty;
    logic             fire, mispredict, fits;
    logic [63:0]      correct_pc, diff;
    logic [63:OFF_W-1] diff_hi;

    logic             start_d, bcond_d, taken_d, inc_d, flush_d;
    logic [63:0]      pc_d;
    logic [OFF_W-1:0] off_d;

    assign bus.dq_ready = !fifo_full && (state_q == ST_IDLE);
    assign bus.ex_ready = !fifo_empty && (state_q == ST_IDLE);
    assign fire         = bus.ex_valid && bus.ex_ready;

    assign correct_pc = bus.ex_taken ? bus.ex_target : fallthrough_pc(head.pc);
    assign mispredict = (head.pred_taken != bus.ex_taken) ||
                        (bus.ex_taken && (head.pred_target != bus.ex_target));
    assign diff       = correct_pc - head.pc;
    // Fits in signed OFF_W when all bits above the sign bit replicate it.
    assign diff_hi    = diff[63:OFF_W-1];
    assign fits       = (&diff_hi) || !(|diff_hi);

    branch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk_in),
        .rst_n     (rst_N_in),
        .push      (bus.dq_valid && bus.dq_ready),
        .push_data ('{pc: bus.dq_pc, kind: bus.dq_kind,
                      pred_taken: bus.dq_pred_taken, pred_target: bus.dq_pred_target}),
        .pop       (fire),
        .flush     (fire && mispredict),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_N_in) begin
            state_q  <= ST_BOOT;
            fix_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            fix_pc_q <= fix_pc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        fix_pc_d = fix_pc_q;
        start_d  = 1'b0;
        bcond_d  = 1'b0;
        taken_d  = 1'b0;
        pc_d     = '0;
        inc_d    = 1'b0;
        off_d    = '0;
        flush_d  = 1'b0;
        case (state_q)
            ST_BOOT: begin
                start_d = 1'b1;
                pc_d    = RESET_PC;
                state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (fire) begin
                    bcond_d = (head.kind == BCOND);
                    taken_d = bus.ex_taken;
                    pc_d    = head.pc;
                    if (mispredict) begin
                        flush_d = 1'b1;
                        if (fits) begin
                            inc_d = 1'b1;
                            off_d = diff[OFF_W-1:0];
                        end else begin
                            // PHT update stays on branch PC; redirect follows.
                            fix_pc_d = correct_pc;
                            state_d  = ST_FIX;
                        end
                    end
                end
            end
            ST_FIX: begin
                pc_d    = fix_pc_q;
                inc_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_N_in) begin
            start_signal        <= 1'b0;
            x_bcond_resolved    <= 1'b0;
            x_taken             <= 1'b0;
            x_pc                <= '0;
            x_pc_incorrect      <= 1'b0;
            x_correction_offset <= '0;
            flush_out           <= 1'b0;
            bru_err             <= 1'b0;
        end else begin
            start_signal        <= start_d;
            x_bcond_resolved    <= bcond_d;
            x_taken             <= taken_d;
            x_pc                <= pc_d;
            x_pc_incorrect      <= inc_d;
            x_correction_offset <= off_d;
            flush_out           <= flush_d;
            bru_err             <= bru_err | (bus.ex_valid & fifo_empty);
        end
    end

`ifdef BRU_STATS_EN
    always_ff @(posedge clk_in) begin
        if (!rst_N_in) begin
            stat_resolved <= '0;
            stat_mispred  <= '0;
        end else begin
            if (fire && (stat_resolved != '1))
                stat_resolved <= stat_resolved + 32'd1;
            if (fire && mispredict && (stat_mispred != '1))
                stat_mispred <= stat_mispred + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: a reference FIFO model predicts each
// resolve and queues expected outputs, compared one cycle after the handshake.
module tb_branch_resolve_unit;
    import uop_pkg::*;

    logic        clk_in = 1'b0;
    logic        rst_N_in;
    logic        start_signal, x_bcond_resolved, x_taken, x_pc_incorrect, flush_out, bru_err;
    logic [63:0] x_pc;
    logic [18:0] x_correction_offset;
`ifdef BRU_STATS_EN
    logic [31:0] stat_resolved, stat_mispred;
`endif

    always #5 clk_in = ~clk_in;

    branch_resolve_unit_if bus();

    branch_resolve_unit dut (
        .clk_in              (clk_in),
        .rst_N_in            (rst_N_in),
        .bus                 (bus),
        .start_signal        (start_signal),
        .x_bcond_resolved    (x_bcond_resolved),
        .x_taken             (x_taken),
        .x_pc                (x_pc),
        .x_pc_incorrect      (x_pc_incorrect),
        .x_correction_offset (x_correction_offset),
        .flush_out           (flush_out),
        .bru_err             (bru_err)
`ifdef BRU_STATS_EN
        ,
        .stat_resolved       (stat_resolved),
        .stat_mispred        (stat_mispred)
`endif
    );

    typedef struct {
        logic        st;
        logic        bc;
        logic        tk;
        logic        chk_tk;
        logic [63:0] pc;
        logic        chk_pc;
        logic        inc;
        logic [18:0] off;
        logic        fl;
    } exp_t;

    exp_t       exp_q[$];
    bru_entry_t m_q[$];
    logic       m_err;
    logic       m_idle;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic exp_t idle_rec();
        exp_t r;
        r = '{default: 0};
        r.chk_tk = 1'b1;
        return r;
    endfunction

    function automatic bru_entry_t ent(input logic [63:0] pc, input branch_kind_e k,
                                       input logic pt, input logic [63:0] ptg);
        bru_entry_t e;
        e.pc = pc;
        e.kind = k;
        e.pred_taken = pt;
        e.pred_target = ptg;
        return e;
    endfunction

    // Reference resolve: queues one record, or two for an out-of-range redirect.
    task automatic push_resolve(input bru_entry_t h, input logic tk, input logic [63:0] tgt,
                                output logic misp, output logic fix);
        logic [63:0]        correct;
        logic signed [63:0] sdiff;
        exp_t               r, r2;
        correct = tk ? tgt : h.pc + 64'd4;
        misp    = (h.pred_taken != tk) || (tk && (h.pred_target != tgt));
        sdiff   = correct - h.pc;
        fix     = 1'b0;
        r = idle_rec();
        r.bc = (h.kind == BCOND);
        r.tk = tk;
        r.pc = h.pc;
        r.chk_pc = 1'b1;
        if (misp) begin
            r.fl = 1'b1;
            if ((sdiff >= -64'sd262144) && (sdiff <= 64'sd262143)) begin
                r.inc = 1'b1;
                r.off = sdiff[18:0];
            end else begin
                fix = 1'b1;
            end
        end
        exp_q.push_back(r);
        if (fix) begin
            r2 = idle_rec();
            r2.pc = correct;
            r2.chk_pc = 1'b1;
            r2.inc = 1'b1;
            r2.chk_tk = 1'b0;
            exp_q.push_back(r2);
        end
    endtask

    task automatic check_out(input string tag);
        exp_t r;
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL %s.queue: observed empty expected record", tag);
        end
        if (exp_q.size() != 0) begin
            r = exp_q.pop_front();
            chk({tag, ".start"}, 64'(start_signal), 64'(r.st));
            chk({tag, ".bcond"}, 64'(x_bcond_resolved), 64'(r.bc));
            if (r.chk_tk) chk({tag, ".taken"}, 64'(x_taken), 64'(r.tk));
            if (r.chk_pc) chk({tag, ".x_pc"}, x_pc, r.pc);
            chk({tag, ".incorrect"}, 64'(x_pc_incorrect), 64'(r.inc));
            chk({tag, ".offset"}, 64'(x_correction_offset), 64'(r.off));
            chk({tag, ".flush"}, 64'(flush_out), 64'(r.fl));
            chk({tag, ".bru_err"}, 64'(bru_err), 64'(m_err));
        end
    endtask

    task automatic cycle(input logic do_enq, input bru_entry_t e, input logic do_ex,
                         input logic tk, input logic [63:0] tgt, input string tag);
        logic       dr, er, misp, fix;
        bru_entry_t h;
        dr = m_idle && (m_q.size() < 8);
        er = m_idle && (m_q.size() != 0);
        chk({tag, ".dq_ready"}, 64'(bus.dq_ready), 64'(dr));
        chk({tag, ".ex_ready"}, 64'(bus.ex_ready), 64'(er));
        bus.dq_valid       = do_enq;
        bus.dq_pc          = e.pc;
        bus.dq_kind        = e.kind;
        bus.dq_pred_taken  = e.pred_taken;
        bus.dq_pred_target = e.pred_target;
        bus.ex_valid       = do_ex;
        bus.ex_taken       = tk;
        bus.ex_target      = tgt;
        misp = 1'b0;
        fix  = 1'b0;
        if (do_ex && (m_q.size() == 0)) m_err = 1'b1;
        if (do_ex && er) begin
            h = m_q.pop_front();
            push_resolve(h, tk, tgt, misp, fix);
        end else begin
            exp_q.push_back(idle_rec());
        end
        if (misp) m_q.delete();
        else if (do_enq && dr) m_q.push_back(e);
        tick();
        bus.dq_valid = 1'b0;
        bus.ex_valid = 1'b0;
        check_out(tag);
        if (fix) begin
            m_idle = 1'b0;
            chk({tag, ".fix_dq_ready"}, 64'(bus.dq_ready), 64'(0));
            chk({tag, ".fix_ex_ready"}, 64'(bus.ex_ready), 64'(0));
            tick();
            m_idle = 1'b1;
            check_out({tag, ".fix"});
        end
    endtask

    task automatic boot_seq(input string tag);
        exp_t r;
        r = idle_rec();
        r.st = 1'b1;
        r.pc = 64'h0;
        r.chk_pc = 1'b1;
        exp_q.push_back(r);
        rst_N_in = 1'b1;
        tick();
        check_out(tag);
        m_idle = 1'b1;
        cycle(1'b0, ent(0, BCOND, 0, 0), 1'b0, 1'b0, 64'h0, {tag, "_after"});
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".start"}, 64'(start_signal), 64'(0));
        chk({tag, ".bcond"}, 64'(x_bcond_resolved), 64'(0));
        chk({tag, ".taken"}, 64'(x_taken), 64'(0));
        chk({tag, ".x_pc"}, x_pc, 64'h0);
        chk({tag, ".incorrect"}, 64'(x_pc_incorrect), 64'(0));
        chk({tag, ".offset"}, 64'(x_correction_offset), 64'(0));
        chk({tag, ".flush"}, 64'(flush_out), 64'(0));
        chk({tag, ".bru_err"}, 64'(bru_err), 64'(0));
        chk({tag, ".dq_ready"}, 64'(bus.dq_ready), 64'(0));
        chk({tag, ".ex_ready"}, 64'(bus.ex_ready), 64'(0));
    endtask

    initial begin
        bru_entry_t nul, h;
        logic       misp, fix;
        nul = ent(0, BCOND, 0, 0);
        rst_N_in = 1'b0;
        bus.dq_valid = 1'b0; bus.dq_pc = '0; bus.dq_kind = BCOND;
        bus.dq_pred_taken = 1'b0; bus.dq_pred_target = '0;
        bus.ex_valid = 1'b0; bus.ex_taken = 1'b0; bus.ex_target = '0;
        m_err = 1'b0;
        m_idle = 1'b0;
        repeat (3) tick();

        check_reset_outputs("reset");
        boot_seq("boot");

        cycle(1, ent(64'h100, BCOND, 0, 0), 0, 0, 0, "t2_enq");
        cycle(0, nul, 1, 0, 64'h0, "t2_res");

        cycle(1, ent(64'h100, BCOND, 0, 0), 0, 0, 0, "t3_enq");
        cycle(0, nul, 1, 1, 64'h140, "t3_res");
        cycle(0, nul, 0, 0, 0, "t3_empty");

        cycle(1, ent(64'h1000, RET, 1, 64'h2000), 0, 0, 0, "t4_enq");
        cycle(0, nul, 1, 1, 64'h9000_0000, "t4_res");

        cycle(1, ent(64'h400, BCOND, 1, 64'h480), 0, 0, 0, "nt_enq");
        cycle(0, nul, 1, 0, 64'h0, "nt_res");
        cycle(1, ent(64'h2000, BL, 1, 64'h3000), 0, 0, 0, "back_enq");
        cycle(0, nul, 1, 1, 64'h1F00, "back_res");
        cycle(1, ent(64'h10000, B, 1, 64'h10000), 0, 0, 0, "max_enq");
        cycle(0, nul, 1, 1, 64'h4FFFF, "max_res");
        cycle(1, ent(64'h80000, B, 1, 64'h0), 0, 0, 0, "min_enq");
        cycle(0, nul, 1, 1, 64'h40000, "min_res");
        cycle(1, ent(64'h10000, B, 1, 64'h0), 0, 0, 0, "over_enq");
        cycle(0, nul, 1, 1, 64'h50000, "over_res");
        cycle(1, ent(64'h500, BL, 1, 64'h600), 0, 0, 0, "hit_enq");
        cycle(0, nul, 1, 1, 64'h600, "hit_res");

        for (int i = 0; i < 8; i++)
            cycle(1, ent(64'h200 + 64'(16 * i), BCOND, 0, 0), 0, 0, 0, "t5_fill");
        cycle(1, ent(64'h2F0, BCOND, 0, 0), 0, 0, 0, "t5_full");
        cycle(0, nul, 1, 0, 64'h0, "t5_pop");
        cycle(1, ent(64'h300, BCOND, 0, 0), 1, 0, 64'h0, "t5_both");
        cycle(1, ent(64'h310, BCOND, 0, 0), 0, 0, 0, "t5_refill");
        cycle(0, nul, 0, 0, 0, "t5_full2");
        cycle(0, nul, 1, 0, 64'h0, "t5_pop2");
        cycle(1, ent(64'h320, BCOND, 0, 0), 1, 1, 64'h999, "t5_misp");
        cycle(0, nul, 0, 0, 0, "t5_empty");

        cycle(0, nul, 1, 0, 64'h0, "t6_err");
        cycle(0, nul, 0, 0, 0, "t6_sticky");
        cycle(1, ent(64'h1000, RET, 1, 64'h2000), 0, 0, 0, "t6_enq");

        bus.ex_valid = 1'b1;
        bus.ex_taken = 1'b1;
        bus.ex_target = 64'h9000_0000;
        h = m_q.pop_front();
        push_resolve(h, 1'b1, 64'h9000_0000, misp, fix);
        m_q.delete();
        tick();
        bus.ex_valid = 1'b0;
        check_out("t6_fix1");
        exp_q.delete();
        rst_N_in = 1'b0;
        tick();
        check_reset_outputs("t6_rst");
        tick();
        m_err = 1'b0;
        m_idle = 1'b0;
        boot_seq("t6_boot");
        cycle(1, ent(64'h700, BCOND, 1, 64'h800), 0, 0, 0, "t6_enq2");
        cycle(0, nul, 1, 1, 64'h800, "t6_res2");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
